regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Owns the single write port (A3/WD3/WE3) of the 32x32 pipeline register file.
- After reset, a clear sequence writes zero to x1..x31. It then arbitrates between the pipeline writeback stage and a long-latency unit (LLU: divider/load-miss return).
- A starvation guard stalls the pipeline so a waiting LLU result can retire.
- Sits between the WB stage / LLU and the register file; drives the stall line into the hazard unit.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register index width
- NUM_REGS, 32, register count; clear covers indices 1..NUM_REGS-1
- STARVE_LIMIT, 4, consecutive LLU wait cycles before forced grant (>=1)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- pipe_we  in  1  WB-stage write enable
- pipe_rd  in  ADDR_W  WB-stage destination register
- pipe_wd  in  DATA_W  WB-stage write data
- llu_valid  in  1  LLU result pending
- llu_rd  in  ADDR_W  LLU destination register
- llu_wd  in  DATA_W  LLU result data
- llu_ready  out  1  LLU result accepted this cycle
- stall  out  1  freeze pipeline (hazard unit ORs this in)
- rf_we  out  1  to register file WE3
- rf_a3  out  ADDR_W  to register file A3
- rf_wd  out  DATA_W  to register file WD3
- init_done  out  1  clear sequence finished

Behaviour:
- State: FSM {CLEAR, RUN, FORCE}; clear index idx (ADDR_W); wait counter wcnt ($clog2(STARVE_LIMIT+1) bits).
- Reset (async, any time, including mid-clear or mid-FORCE): state=CLEAR, idx=1, wcnt=0.
- While rst=1: rf_we=0, llu_ready=0, stall=1, init_done=0, rf_a3=0, rf_wd=0.
- Write-port outputs are combinational from the current state and inputs. The register file samples them at the following negedge, giving same-cycle write.
- "pipe_req" = pipe_we && pipe_rd!=0. Writes to x0 never occupy the port and never reach the register file.
- CLEAR:
  - rf_we=1, rf_a3=idx, rf_wd=0, stall=1, llu_ready=0, init_done=0; pipe_* and llu_* are ignored.
  - idx increments each cycle.
  - When idx==NUM_REGS-1, the write still occurs that cycle; next state is RUN.
  - Sequence takes exactly NUM_REGS-1 = 31 cycles.
- RUN (init_done=1, stall=0):
  - pipe_req=1: grant pipe. rf_we=1, rf_a3=pipe_rd, rf_wd=pipe_wd, llu_ready=0.
  - Else if llu_valid=1: grant LLU. rf_we=1, rf_a3=llu_rd, rf_wd=llu_wd, llu_ready=1.
  - Else: rf_we=0.
  - wcnt: cleared on any cycle with llu_valid=0 or llu_ready=1; increments when llu_valid && !llu_ready; saturates at STARVE_LIMIT.
  - When the incremented wcnt reaches STARVE_LIMIT, next state is FORCE. The pipe write in the current cycle still completes.
- FORCE (init_done=1, stall=1):
  - The pipeline holds its WB-stage contents while stall=1.
  - pipe_* is ignored; rf_we=0 unless the LLU grant below applies.
  - LLU granted unconditionally when llu_valid=1 (same output values as the RUN LLU grant).
  - After the llu handshake: wcnt=0, next state RUN; stall drops the cycle after.
  - If llu_valid falls without a handshake (LLU flush): wcnt=0, return to RUN.
- Same rd from pipe and LLU in one cycle: pipe wins; the LLU write retires later. Ordering of dependent writes is the scoreboard's responsibility, not this block's.
- llu_rd==0 handshake: llu_ready=1 but rf_we=0 (result dropped).
- LLU inputs must stay stable while llu_valid=1 && llu_ready=0.
- init_done stays 1 until the next reset.

Decomposition:
- Shared package rf_pkg holds:
  - localparams DATA_W/ADDR_W/NUM_REGS
  - enum wb_arb_state_t {CLEAR, RUN, FORCE}
  - constant REG_ZERO = 0
- Optional sub-module wb_starve_ctr: the saturating wait counter with limit compare, one instance.
- Grant mux stays inline.

Test Plan:
- Reset clear: release rst, idle inputs -> 31 cycles of rf_we=1 with rf_a3=1..31 and rf_wd=0; stall=1 throughout; init_done=1 and stall=0 on cycle 32; x7 reads 0 afterwards.
- Priority: RUN, pipe_we=1 rd=5 wd=0x6, llu_valid=1 rd=9 wd=0x2004 -> cycle 1: rf_a3=5, llu_ready=0; pipe_we=0 next cycle -> rf_a3=9, rf_wd=0x2004, llu_ready=1.
- Starvation: STARVE_LIMIT=4, pipe_req=1 every cycle with llu_valid=1 -> after 4 denied cycles stall=1 and the pipe write is suppressed; LLU granted (llu_ready=1) in FORCE; stall=0 the cycle after the handshake.
- x0 filtering: pipe_we=1 rd=0 with llu_valid=1 rd=8 wd=0x456 -> LLU granted same cycle, rf_a3=8; llu rd=0 handshake -> llu_ready=1, rf_we=0.
- Reset mid-operation: assert rst at clear index 12, and again during FORCE -> outputs go to reset values immediately (async); the clear sequence restarts from idx=1 and runs the full 31 cycles.
- Flush in FORCE: llu_valid drops before the handshake -> state returns to RUN, stall=0 next cycle, wcnt=0.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared types and sizing for the register-file write-port arbiter.
package rf_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  typedef enum logic [1:0] {
    CLEAR,
    RUN,
    FORCE
  } wb_arb_state_t;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of WB-stage, LLU and register-file write-port signals around the arbiter.
interface regfile_wb_arbiter_if;
  import rf_pkg::*;

  logic              pipe_we;
  logic [ADDR_W-1:0] pipe_rd;
  logic [DATA_W-1:0] pipe_wd;
  logic              llu_valid;
  logic [ADDR_W-1:0] llu_rd;
  logic [DATA_W-1:0] llu_wd;
  logic              llu_ready;
  logic              stall;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_a3;
  logic [DATA_W-1:0] rf_wd;
  logic              init_done;

  modport master (
    output pipe_we, pipe_rd, pipe_wd, llu_valid, llu_rd, llu_wd,
    input  llu_ready, stall, rf_we, rf_a3, rf_wd, init_done
  );

  modport slave (
    input  pipe_we, pipe_rd, pipe_wd, llu_valid, llu_rd, llu_wd,
    output llu_ready, stall, rf_we, rf_a3, rf_wd, init_done
  );

endinterface

// File: rtl/wb_starve_ctr.sv
// Saturating count of cycles an LLU result has been denied the write port.
module wb_starve_ctr #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic clr_i,
  output logic hit_o
);

  localparam int CNT_W = $clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

  logic [CNT_W-1:0] wcnt_q, wcnt_d, wcnt_inc;

  always_comb begin
    wcnt_inc = (wcnt_q == LIMIT_C) ? wcnt_q : wcnt_q + CNT_W'(1);
    wcnt_d   = wcnt_q;
    if (clr_i) begin
      wcnt_d = '0;
    end else if (inc_i) begin
      wcnt_d = wcnt_inc;
    end
    hit_o = inc_i && !clr_i && (wcnt_inc == LIMIT_C);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt_q <= '0;
    end else begin
      wcnt_q <= wcnt_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Owns the register-file write port: post-reset clear, then WB-vs-LLU arbitration
// with a starvation guard that stalls the pipeline to retire a waiting LLU result.
module regfile_wb_arbiter
  import rf_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input logic                  clk,
  input logic                  rst,
  regfile_wb_arbiter_if.slave  bus
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  wb_arb_state_t     state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;

  logic              pipe_req;
  logic              cnt_inc, cnt_clr, starve_hit;
  logic              we, ready, stall, init_done;
  logic [ADDR_W-1:0] a3;
  logic [DATA_W-1:0] wd;

  assign pipe_req = bus.pipe_we && (bus.pipe_rd != REG_ZERO);

  wb_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk   (clk),
    .rst   (rst),
    .inc_i (cnt_inc),
    .clr_i (cnt_clr),
    .hit_o (starve_hit)
  );

  // Write-port outputs are combinational so the register file can capture them at the negedge.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    we        = 1'b0;
    a3        = REG_ZERO;
    wd        = '0;
    ready     = 1'b0;
    stall     = 1'b0;
    init_done = 1'b1;
    cnt_inc   = 1'b0;
    cnt_clr   = 1'b0;

    case (state_q)
      CLEAR: begin
        we        = 1'b1;
        a3        = idx_q;
        stall     = 1'b1;
        init_done = 1'b0;
        cnt_clr   = 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = RUN;
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
      end
      RUN: begin
        if (pipe_req) begin
          we = 1'b1;
          a3 = bus.pipe_rd;
          wd = bus.pipe_wd;
        end else if (bus.llu_valid) begin
          ready = 1'b1;
          we    = (bus.llu_rd != REG_ZERO);
          a3    = bus.llu_rd;
          wd    = bus.llu_wd;
        end
        cnt_inc = bus.llu_valid && pipe_req;
        cnt_clr = !bus.llu_valid || ready;
        if (starve_hit) begin
          state_d = FORCE;
        end
      end
      FORCE: begin
        stall   = 1'b1;
        cnt_clr = 1'b1;
        if (bus.llu_valid) begin
          ready = 1'b1;
          we    = (bus.llu_rd != REG_ZERO);
          a3    = bus.llu_rd;
          wd    = bus.llu_wd;
        end
        // Either the handshake completed or the LLU flushed; both resume normal arbitration.
        state_d = RUN;
      end
      default: begin
        state_d = CLEAR;
      end
    endcase

    if (rst) begin
      we        = 1'b0;
      a3        = REG_ZERO;
      wd        = '0;
      ready     = 1'b0;
      stall     = 1'b1;
      init_done = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLEAR;
      idx_q   <= ADDR_W'(1);
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.rf_we     = we;
  assign bus.rf_a3     = a3;
  assign bus.rf_wd     = wd;
  assign bus.llu_ready = ready;
  assign bus.stall     = stall;
  assign bus.init_done = init_done;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench: clear sequence, priority, starvation, x0 filtering,
// FORCE flush and asynchronous reset during clear and FORCE.
module tb_regfile_wb_arbiter;
  import rf_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic x0Written;
  logic [DATA_W-1:0] rfModel [NUM_REGS];

  regfile_wb_arbiter_if rfIf();

  regfile_wb_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (rfIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file model: captures the write port on the negedge, like the real array.
  always @(negedge clk) begin
    if (rfIf.rf_we) begin
      if (rfIf.rf_a3 == REG_ZERO) x0Written = 1'b1;
      else rfModel[rfIf.rf_a3] <= rfIf.rf_wd;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic pWe, input logic [4:0] pRd, input logic [31:0] pWd,
                               input logic lV, input logic [4:0] lRd, input logic [31:0] lWd);
    @(posedge clk);
    #1;
    rfIf.pipe_we   = pWe;
    rfIf.pipe_rd   = pRd;
    rfIf.pipe_wd   = pWd;
    rfIf.llu_valid = lV;
    rfIf.llu_rd    = lRd;
    rfIf.llu_wd    = lWd;
    #2;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_we"}, 32'(rfIf.rf_we), 32'd0);
    checkOutput({tag, "_ready"}, 32'(rfIf.llu_ready), 32'd0);
    checkOutput({tag, "_stall"}, 32'(rfIf.stall), 32'd1);
    checkOutput({tag, "_init"}, 32'(rfIf.init_done), 32'd0);
    checkOutput({tag, "_a3"}, 32'(rfIf.rf_a3), 32'd0);
    checkOutput({tag, "_wd"}, rfIf.rf_wd, 32'd0);
  endtask

  task automatic releaseReset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #2;
  endtask

  // Walks the clear sequence; abortAt>0 asserts reset in the cycle that clears that index.
  task automatic runClear(input int abortAt);
    for (int i = 1; i <= NUM_REGS - 1; i++) begin
      checkOutput("clearA3", 32'(rfIf.rf_a3), 32'(i));
      checkOutput("clearWe", 32'(rfIf.rf_we), 32'd1);
      checkOutput("clearWd", rfIf.rf_wd, 32'd0);
      checkOutput("clearStall", 32'(rfIf.stall), 32'd1);
      checkOutput("clearInit", 32'(rfIf.init_done), 32'd0);
      if (i == abortAt) begin
        rst = 1'b1;
        #1;
        checkReset("midClearRst");
        return;
      end
      applyStimulus(0, 0, 0, 0, 0, 0);
    end
    checkOutput("doneInit", 32'(rfIf.init_done), 32'd1);
    checkOutput("doneStall", 32'(rfIf.stall), 32'd0);
    checkOutput("doneWe", 32'(rfIf.rf_we), 32'd0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    x0Written = 1'b0;
    rst       = 1'b1;
    rfIf.pipe_we = 0; rfIf.pipe_rd = 0; rfIf.pipe_wd = 0;
    rfIf.llu_valid = 0; rfIf.llu_rd = 0; rfIf.llu_wd = 0;
    #12;
    checkReset("inReset");

    releaseReset();
    runClear(0);
    checkOutput("x7Cleared", rfModel[7], 32'd0);
    checkOutput("x31Cleared", rfModel[31], 32'd0);

    // Pipe wins over LLU, then LLU retires once the pipe is quiet.
    applyStimulus(1, 5, 32'h6, 1, 9, 32'h2004);
    checkOutput("prioA3", 32'(rfIf.rf_a3), 32'd5);
    checkOutput("prioWd", rfIf.rf_wd, 32'h6);
    checkOutput("prioReady", 32'(rfIf.llu_ready), 32'd0);
    applyStimulus(0, 0, 0, 1, 9, 32'h2004);
    checkOutput("lluA3", 32'(rfIf.rf_a3), 32'd9);
    checkOutput("lluWd", rfIf.rf_wd, 32'h2004);
    checkOutput("lluReady", 32'(rfIf.llu_ready), 32'd1);
    checkOutput("lluWe", 32'(rfIf.rf_we), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("idleWe", 32'(rfIf.rf_we), 32'd0);
    checkOutput("x5Written", rfModel[5], 32'h6);
    checkOutput("x9Written", rfModel[9], 32'h2004);

    // Starvation: four denied cycles, then FORCE grants the LLU.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 10, 32'hA0 + 32'(i), 1, 11, 32'hB0B);
      checkOutput("starveA3", 32'(rfIf.rf_a3), 32'd10);
      checkOutput("starveStall", 32'(rfIf.stall), 32'd0);
      checkOutput("starveReady", 32'(rfIf.llu_ready), 32'd0);
    end
    applyStimulus(1, 10, 32'hA4, 1, 11, 32'hB0B);
    checkOutput("forceStall", 32'(rfIf.stall), 32'd1);
    checkOutput("forceA3", 32'(rfIf.rf_a3), 32'd11);
    checkOutput("forceWd", rfIf.rf_wd, 32'hB0B);
    checkOutput("forceReady", 32'(rfIf.llu_ready), 32'd1);
    checkOutput("forceInit", 32'(rfIf.init_done), 32'd1);
    applyStimulus(1, 10, 32'hA4, 0, 0, 0);
    checkOutput("afterForceStall", 32'(rfIf.stall), 32'd0);
    checkOutput("afterForceA3", 32'(rfIf.rf_a3), 32'd10);
    checkOutput("x10Last", rfModel[10], 32'hA3);
    checkOutput("x11Llu", rfModel[11], 32'hB0B);

    // x0 writes never occupy or reach the port.
    applyStimulus(1, 0, 32'h999, 1, 8, 32'h456);
    checkOutput("x0LluA3", 32'(rfIf.rf_a3), 32'd8);
    checkOutput("x0LluWd", rfIf.rf_wd, 32'h456);
    checkOutput("x0LluReady", 32'(rfIf.llu_ready), 32'd1);
    applyStimulus(0, 0, 0, 1, 0, 32'h777);
    checkOutput("lluRd0Ready", 32'(rfIf.llu_ready), 32'd1);
    checkOutput("lluRd0We", 32'(rfIf.rf_we), 32'd0);
    applyStimulus(1, 0, 32'h5, 0, 0, 0);
    checkOutput("pipeRd0We", 32'(rfIf.rf_we), 32'd0);

    // Flush while in FORCE, then confirm the wait count restarted from zero.
    for (int i = 0; i < 4; i++) applyStimulus(1, 12, 32'hC0, 1, 13, 32'hD0);
    applyStimulus(1, 12, 32'hC1, 0, 0, 0);
    checkOutput("flushStall", 32'(rfIf.stall), 32'd1);
    checkOutput("flushWe", 32'(rfIf.rf_we), 32'd0);
    checkOutput("flushReady", 32'(rfIf.llu_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 12, 32'hC2, 1, 13, 32'hD1);
      checkOutput("postFlushStall", 32'(rfIf.stall), 32'd0);
      checkOutput("postFlushA3", 32'(rfIf.rf_a3), 32'd12);
    end
    applyStimulus(1, 12, 32'hC2, 1, 13, 32'hD1);
    checkOutput("reforceStall", 32'(rfIf.stall), 32'd1);
    checkOutput("reforceA3", 32'(rfIf.rf_a3), 32'd13);

    // Asynchronous reset mid-FORCE, then again mid-clear, then a full clear.
    rst = 1'b1;
    #1;
    checkReset("forceRst");
    releaseReset();
    runClear(12);
    releaseReset();
    runClear(0);
    checkOutput("x5Recleared", rfModel[5], 32'd0);
    checkOutput("x11Recleared", rfModel[11], 32'd0);
    checkOutput("x0NeverWritten", 32'(x0Written), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

endmodule
